keypad_entry_ctrl: RTL and testbench

Controller that sequences keypad scanning for the input_control path. It debounces a one-hot 10-key digit pad plus ENTER/CANCEL keys, and enforces release-before-next-key. Accepted digits are assembled into a fixed-width BCD code. The finished code is handed to the consuming lock/compare logic over a valid/ready handshake.

---
 rtl/keypad_entry_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces a one-hot digit pad plus ENTER/CANCEL,
// assembles accepted digits into a BCD code and offers it over valid/ready.
module keypad_entry_ctrl #(
  parameter int N_DIGITS        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [9:0]              keypad,
  input  logic                    key_enter,
  input  logic                    key_cancel,
  output logic [4*N_DIGITS-1:0]   code,
  output logic [3:0]              digit_count,
  output logic                    code_valid,
  input  logic                    code_ready,
  output logic                    key_pulse,
  output logic                    err_pulse,
  output logic                    busy
);

  localparam int          CW     = 4 * N_DIGITS;
  localparam logic [7:0]  DEB    = 8'(DEBOUNCE_CYCLES);
  localparam logic [3:0]  NDIG   = 4'(N_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS   = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [11:0]     latch_q, latch_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [CW-1:0]   code_q, code_d;
  logic [3:0]      count_q, count_d;
  logic            valid_q, valid_d;
  logic            kp_q, kp_d;
  logic            ep_q, ep_d;
  logic            busy_q, busy_d;
  logic [11:0]     sample_s;
  logic [7:0]      cnt_inc_s;

  function automatic logic is_onehot(input logic [11:0] v);
    return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
  endfunction

  function automatic logic [3:0] digit_of(input logic [11:0] v);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        d = 4'(i);
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  assign sample_s  = {key_cancel, key_enter, keypad};
  assign cnt_inc_s = cnt_q + 8'd1;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      latch_q <= 12'd0;
      cnt_q   <= 8'd0;
      code_q  <= '0;
      count_q <= 4'd0;
      valid_q <= 1'b0;
      kp_q    <= 1'b0;
      ep_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      count_q <= count_d;
      valid_q <= valid_d;
      kp_q    <= kp_d;
      ep_q    <= ep_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, debounce counting and key acceptance
  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    count_d = count_q;
    valid_d = valid_q;
    kp_d    = 1'b0;
    ep_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_onehot(sample_s)) begin
          latch_d = sample_s;
          cnt_d   = 8'd1;
          state_d = S_PRESS;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PRESS: begin
        if (sample_s == latch_q) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == DEB) begin
            state_d = S_HOLD;
            if (latch_q[11]) begin
              code_d  = '0;
              count_d = 4'd0;
            end else if (latch_q[10]) begin
              if (count_q == 4'd0) begin
                ep_d = 1'b1;
              end else begin
                valid_d = 1'b1;
                state_d = S_DONE;
              end
            end else if (count_q < NDIG) begin
              // Newest digit lands in the low nibble, older ones move up
              code_d      = code_q << 4;
              code_d[3:0] = digit_of(latch_q);
              count_d     = count_q + 4'd1;
              kp_d        = 1'b1;
            end else begin
              ep_d = 1'b1;
            end
          end else begin
            state_d = S_PRESS;
          end
        end else if (is_onehot(sample_s)) begin
          latch_d = sample_s;
          cnt_d   = 8'd1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HOLD: begin
        if (sample_s == 12'd0) begin
          cnt_d   = 8'd1;
          state_d = S_RELEASE;
        end else begin
          state_d = S_HOLD;
        end
      end

      S_RELEASE: begin
        if (sample_s == 12'd0) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == DEB) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          state_d = S_HOLD;
        end
      end

      S_DONE: begin
        if (code_ready) begin
          valid_d = 1'b0;
          code_d  = '0;
          count_d = 4'd0;
          state_d = S_HOLD;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign code        = code_q;
  assign digit_count = count_q;
  assign code_valid  = valid_q;
  assign key_pulse   = kp_q;
  assign err_pulse   = ep_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: stimulus queues expected events and
// status snapshots, a negedge monitor pops and compares them.
module tb_keypad_entry_ctrl;

  localparam int K_KEY = 0;
  localparam int K_ERR = 1;
  localparam int K_VAL = 2;

  localparam logic [11:0] ENTER  = 12'h400;
  localparam logic [11:0] CANCEL = 12'h800;

  typedef struct {
    int          kind;
    logic [15:0] code;
    logic [3:0]  cnt;
  } ev_t;

  typedef struct {
    int          id;
    logic [15:0] code;
    logic [3:0]  cnt;
    logic        valid;
    logic        busy;
  } snap_t;

  logic        clk = 1'b0;
  logic        clear;
  logic [9:0]  keypad;
  logic        key_enter;
  logic        key_cancel;
  logic [15:0] code;
  logic [3:0]  digit_count;
  logic        code_valid;
  logic        code_ready;
  logic        key_pulse;
  logic        err_pulse;
  logic        busy;

  ev_t   ev_q[$];
  snap_t snap_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  end_req = 1'b0;
  logic  prev_kp = 1'b0;
  logic  prev_ep = 1'b0;
  logic  prev_valid = 1'b0;
  ev_t   e_m;
  snap_t s_m;

  keypad_entry_ctrl #(.N_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .clear(clear), .keypad(keypad), .key_enter(key_enter),
    .key_cancel(key_cancel), .code(code), .digit_count(digit_count),
    .code_valid(code_valid), .code_ready(code_ready), .key_pulse(key_pulse),
    .err_pulse(err_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setk(input logic [11:0] v);
    {key_cancel, key_enter, keypad} = v;
  endtask

  task automatic press(input logic [11:0] v, input int hold, input int rel);
    setk(v);
    tick(hold);
    setk(12'd0);
    tick(rel);
  endtask

  task automatic exp_ev(input int kind, input logic [15:0] c, input logic [3:0] n);
    ev_t e;
    e.kind = kind; e.code = c; e.cnt = n;
    ev_q.push_back(e);
  endtask

  task automatic snap(input int id, input logic [15:0] c, input logic [3:0] n,
                      input logic v, input logic b);
    snap_t s;
    s.id = id; s.code = c; s.cnt = n; s.valid = v; s.busy = b;
    snap_q.push_back(s);
  endtask

  task automatic digit(input int d, input logic [15:0] c, input logic [3:0] n);
    exp_ev(K_KEY, c, n);
    press(12'(1) << d, 4, 4);
  endtask

  // Compare an observed output event against the head of the expectation queue
  task automatic check_ev(input int kind);
    n_tests++;
    if (ev_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d code %h cnt %0d, required none", kind, code, digit_count);
    end else begin
      e_m = ev_q.pop_front();
      if (e_m.kind != kind || code !== e_m.code || digit_count !== e_m.cnt) begin
        n_fail++;
        $display("FAIL event: got kind %0d code %h cnt %0d, required kind %0d code %h cnt %0d",
                 kind, code, digit_count, e_m.kind, e_m.code, e_m.cnt);
      end
    end
  endtask

  // Monitor: pops snapshots and events, checks pulse invariants
  always @(negedge clk) begin
    while (snap_q.size() > 0) begin
      s_m = snap_q.pop_front();
      n_tests++;
      if (code !== s_m.code || digit_count !== s_m.cnt ||
          code_valid !== s_m.valid || busy !== s_m.busy) begin
        n_fail++;
        $display("FAIL snap%0d: got code %h cnt %0d valid %b busy %b, required code %h cnt %0d valid %b busy %b",
                 s_m.id, code, digit_count, code_valid, busy, s_m.code, s_m.cnt, s_m.valid, s_m.busy);
      end
    end
    if (key_pulse === 1'b1) check_ev(K_KEY);
    if (err_pulse === 1'b1) check_ev(K_ERR);
    if (code_valid === 1'b1 && prev_valid !== 1'b1) check_ev(K_VAL);
    if (key_pulse === 1'b1 && (err_pulse === 1'b1 || code_valid === 1'b1 || prev_kp === 1'b1)) begin
      n_tests++; n_fail++;
      $display("FAIL key_pulse_excl: got kp %b ep %b valid %b prev_kp %b, required lone 1-cycle pulse",
               key_pulse, err_pulse, code_valid, prev_kp);
    end
    if (err_pulse === 1'b1 && prev_ep === 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL err_pulse_len: got 2+ cycles, required 1");
    end
    prev_kp    = key_pulse;
    prev_ep    = err_pulse;
    prev_valid = code_valid;
    if (end_req) begin
      n_tests++;
      if (ev_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_events: got %0d pending, required 0", ev_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    clear = 1'b1; code_ready = 1'b0; setk(12'd0);
    tick(2);
    clear = 1'b0;
    snap(0, 16'h0000, 4'd0, 1'b0, 1'b0);
    tick(1);

    // single digit with release back to idle
    digit(3, 16'h0003, 4'd1);
    snap(1, 16'h0003, 4'd1, 1'b0, 1'b0);
    press(CANCEL, 4, 4);
    snap(2, 16'h0000, 4'd0, 1'b0, 1'b0);

    // full code with delayed consumer
    digit(1, 16'h0001, 4'd1);
    digit(2, 16'h0012, 4'd2);
    digit(3, 16'h0123, 4'd3);
    digit(4, 16'h1234, 4'd4);
    exp_ev(K_VAL, 16'h1234, 4'd4);
    press(ENTER, 4, 10);
    snap(3, 16'h1234, 4'd4, 1'b1, 1'b1);
    press(12'h004, 4, 0);
    snap(4, 16'h1234, 4'd4, 1'b1, 1'b1);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    snap(5, 16'h0000, 4'd0, 1'b0, 1'b1);
    tick(5);
    snap(6, 16'h0000, 4'd0, 1'b0, 1'b0);

    // bounce: short drop restarts the count, two-cycle press is ignored
    setk(12'h020); tick(3); setk(12'd0); tick(1);
    digit(5, 16'h0005, 4'd1);
    press(12'h020, 2, 4);
    snap(7, 16'h0005, 4'd1, 1'b0, 1'b0);
    press(CANCEL, 4, 4);

    // rejections: fifth digit, empty ENTER, two digits at once
    digit(1, 16'h0001, 4'd1);
    digit(2, 16'h0012, 4'd2);
    digit(3, 16'h0123, 4'd3);
    digit(4, 16'h1234, 4'd4);
    exp_ev(K_ERR, 16'h1234, 4'd4);
    press(12'h200, 4, 4);
    snap(8, 16'h1234, 4'd4, 1'b0, 1'b0);
    press(CANCEL, 4, 4);
    exp_ev(K_ERR, 16'h0000, 4'd0);
    press(ENTER, 4, 4);
    press(12'h006, 6, 4);
    snap(9, 16'h0000, 4'd0, 1'b0, 1'b0);

    // cancel and long hold
    digit(7, 16'h0007, 4'd1);
    digit(8, 16'h0078, 4'd2);
    press(CANCEL, 4, 4);
    snap(10, 16'h0000, 4'd0, 1'b0, 1'b0);
    exp_ev(K_KEY, 16'h0006, 4'd1);
    press(12'h040, 50, 4);
    snap(11, 16'h0006, 4'd1, 1'b0, 1'b0);
    press(CANCEL, 4, 4);

    // clear in PRESS with a stored digit, then clear in DONE
    digit(9, 16'h0009, 4'd1);
    setk(12'h004); tick(2);
    snap(12, 16'h0009, 4'd1, 1'b0, 1'b1);
    clear = 1'b1; setk(12'd0); tick(1); clear = 1'b0;
    snap(13, 16'h0000, 4'd0, 1'b0, 1'b0);
    digit(4, 16'h0004, 4'd1);
    exp_ev(K_VAL, 16'h0004, 4'd1);
    press(ENTER, 4, 3);
    snap(14, 16'h0004, 4'd1, 1'b1, 1'b1);
    clear = 1'b1; tick(1); clear = 1'b0;
    snap(15, 16'h0000, 4'd0, 1'b0, 1'b0);
    digit(1, 16'h0001, 4'd1);
    snap(16, 16'h0001, 4'd1, 1'b0, 1'b0);

    tick(3);
    end_req = 1'b1;
  end

endmodule
